// File: rtl/noc_pkt_framer.sv
`default_nettype none
// ============================================================================
// Module   : noc_pkt_framer
// Purpose  : Store-and-forward NOC packet framer. Buffers each incoming
//            packet, counts its flits and re-emits it with a length header
//            flit prepended.
// Revision : 1.0 - initial release
// ----------------------------------------------------------------------------
// Ports
//   CLK            in   clock, all state on rising edge
//   RST            in   asynchronous active-high reset
//   pi_enq__ENA    in   input flit valid/commit
//   pi_enq__RDY    out  framer can accept a flit this cycle
//   pi_enq_v       in   input flit data (WIDTH)
//   pi_enq_last    in   input flit ends packet
//   po_first__RDY  out  output flit available
//   po_first       out  output flit data (WIDTH)
//   po_first_last  out  output flit ends framed packet
//   po_deq__ENA    in   consumer takes current output flit
//   po_deq__RDY    out  same as po_first__RDY
//   oversize       out  sticky: a packet was truncated
//   pkt_count      out  framed packets fully emitted (wraps)
// ============================================================================
module noc_pkt_framer #(
   parameter int WIDTH     = 128,
   parameter int DEPTH     = 16,
   parameter int LDEPTH    = 4,
   parameter int LEN_WIDTH = 16,
   parameter int TRUNCATE  = 1
) (
   input  logic                 CLK,
   input  logic                 RST,
   input  logic                 pi_enq__ENA,
   output logic                 pi_enq__RDY,
   input  logic [WIDTH-1:0]     pi_enq_v,
   input  logic                 pi_enq_last,
   output logic                 po_first__RDY,
   output logic [WIDTH-1:0]     po_first,
   output logic                 po_first_last,
   input  logic                 po_deq__ENA,
   output logic                 po_deq__RDY,
   output logic                 oversize,
   output logic [LEN_WIDTH-1:0] pkt_count
);

   localparam int c_AW  = $clog2(DEPTH);
   localparam int c_LAW = $clog2(LDEPTH);
   localparam logic [c_AW:0]          c_DONE     = (c_AW+1)'(1);
   localparam logic [c_LAW:0]         c_LONE     = (c_LAW+1)'(1);
   localparam logic [c_LAW:0]         c_LTWO     = (c_LAW+1)'(2);
   localparam logic [LEN_WIDTH-1:0]   c_LEN_ONE  = LEN_WIDTH'(1);
   localparam logic [LEN_WIDTH-1:0]   c_LEN_TWO  = LEN_WIDTH'(2);
   localparam logic [LEN_WIDTH-1:0]   c_LAST_CNT = LEN_WIDTH'(DEPTH-1);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_HDR  = 2'd1,
      S_BODY = 2'd2
   } state_t;

   // storage and pointers (pointer MSB is the wrap bit)
   logic [WIDTH-1:0]     r_dmem [DEPTH];
   logic [LEN_WIDTH-1:0] r_lmem [LDEPTH];
   logic [c_AW:0]        r_dwr, r_drd;
   logic [c_LAW:0]       r_lwr, r_lrd;
   logic [LEN_WIDTH-1:0] r_in_cnt;
   logic                 r_drop;
   logic                 r_oversize;

   state_t               r_state;
   logic [LEN_WIDTH-1:0] r_rem;
   logic                 r_po_rdy;
   logic [WIDTH-1:0]     r_po_data;
   logic                 r_po_last;
   logic [LEN_WIDTH-1:0] r_pkt_count;

   logic                 w_dfull, w_lfull, w_lempty;
   logic [c_LAW:0]       w_lcount;
   logic [c_AW:0]        w_drd_nxt;
   logic [c_LAW:0]       w_lrd_nxt;
   logic                 w_acc, w_wr, w_trunc, w_lpush, w_dpop, w_lpop;
   logic [LEN_WIDTH-1:0] w_plen;
   logic [LEN_WIDTH-1:0] w_lhead;

   assign w_dfull  = (r_dwr[c_AW] != r_drd[c_AW]) && (r_dwr[c_AW-1:0] == r_drd[c_AW-1:0]);
   assign w_lfull  = (r_lwr[c_LAW] != r_lrd[c_LAW]) && (r_lwr[c_LAW-1:0] == r_lrd[c_LAW-1:0]);
   assign w_lempty = (r_lwr == r_lrd);
   assign w_lcount = r_lwr - r_lrd;
   assign w_drd_nxt = r_drd + c_DONE;
   assign w_lrd_nxt = r_lrd + c_LONE;

   // While dropping the tail of a truncated packet nothing is stored, so the
   // input stays open regardless of FIFO occupancy.
   assign pi_enq__RDY = !RST && (r_drop || (!w_dfull && !w_lfull));

   assign w_acc   = pi_enq__ENA && pi_enq__RDY;
   assign w_wr    = w_acc && !r_drop;
   assign w_trunc = (TRUNCATE != 0) && (r_in_cnt == c_LAST_CNT) && !pi_enq_last;
   assign w_lpush = w_wr && (pi_enq_last || w_trunc);
   assign w_plen  = r_in_cnt + c_LEN_ONE;
   assign w_lhead = r_lmem[r_lrd[c_LAW-1:0]];

   assign w_dpop  = (r_state == S_BODY) && po_deq__ENA;
   assign w_lpop  = w_dpop && (r_rem == c_LEN_ONE);

   // ---------------------------------------------------------------------
   // FIFO storage (no reset needed; validity is tracked by the pointers)
   // ---------------------------------------------------------------------
   always_ff @(posedge CLK) begin
      if (w_wr)
         r_dmem[r_dwr[c_AW-1:0]] <= pi_enq_v;
      if (w_lpush)
         r_lmem[r_lwr[c_LAW-1:0]] <= w_plen;
   end

   // ---------------------------------------------------------------------
   // Input side: write pointers, flit counter, truncation/drop control
   // ---------------------------------------------------------------------
   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         r_dwr      <= '0;
         r_lwr      <= '0;
         r_in_cnt   <= '0;
         r_drop     <= 1'b0;
         r_oversize <= 1'b0;
      end else begin
         if (w_wr)
            r_dwr <= r_dwr + c_DONE;
         if (w_lpush)
            r_lwr <= r_lwr + c_LONE;
         if (w_acc) begin
            if (r_drop) begin
               if (pi_enq_last)
                  r_drop <= 1'b0;
            end else if (w_lpush) begin
               r_in_cnt <= '0;
               if (w_trunc) begin
                  r_drop     <= 1'b1;
                  r_oversize <= 1'b1;
               end
            end else begin
               r_in_cnt <= w_plen;
            end
         end
      end
   end

   // ---------------------------------------------------------------------
   // Output state machine. Outputs are registered, so each transition loads
   // the flit that will be presented in the next state. The IDLE->HDR move
   // also looks at a length being pushed this cycle, which puts the header
   // on the output the cycle after the last input flit is accepted.
   // ---------------------------------------------------------------------
   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         r_state     <= S_IDLE;
         r_drd       <= '0;
         r_lrd       <= '0;
         r_rem       <= '0;
         r_po_rdy    <= 1'b0;
         r_po_data   <= '0;
         r_po_last   <= 1'b0;
         r_pkt_count <= '0;
      end else begin
         if (w_dpop)
            r_drd <= w_drd_nxt;
         if (w_lpop)
            r_lrd <= w_lrd_nxt;
         case (r_state)
            S_IDLE: begin
               if (!w_lempty) begin
                  r_state   <= S_HDR;
                  r_po_rdy  <= 1'b1;
                  r_po_data <= WIDTH'(w_lhead);
                  r_po_last <= 1'b0;
               end else if (w_lpush) begin
                  r_state   <= S_HDR;
                  r_po_rdy  <= 1'b1;
                  r_po_data <= WIDTH'(w_plen);
                  r_po_last <= 1'b0;
               end
            end
            S_HDR: begin
               if (po_deq__ENA) begin
                  r_state   <= S_BODY;
                  r_rem     <= w_lhead;
                  r_po_data <= r_dmem[r_drd[c_AW-1:0]];
                  r_po_last <= (w_lhead == c_LEN_ONE);
               end
            end
            S_BODY: begin
               if (po_deq__ENA) begin
                  if (r_rem == c_LEN_ONE) begin
                     r_pkt_count <= r_pkt_count + c_LEN_ONE;
                     r_po_last   <= 1'b0;
                     // the entry being popped is the current packet's length
                     if (w_lcount >= c_LTWO) begin
                        r_state   <= S_HDR;
                        r_po_data <= WIDTH'(r_lmem[w_lrd_nxt[c_LAW-1:0]]);
                     end else if (w_lpush) begin
                        r_state   <= S_HDR;
                        r_po_data <= WIDTH'(w_plen);
                     end else begin
                        r_state   <= S_IDLE;
                        r_po_rdy  <= 1'b0;
                        r_po_data <= '0;
                     end
                  end else begin
                     r_rem     <= r_rem - c_LEN_ONE;
                     r_po_data <= r_dmem[w_drd_nxt[c_AW-1:0]];
                     r_po_last <= (r_rem == c_LEN_TWO);
                  end
               end
            end
            default: begin
               r_state  <= S_IDLE;
               r_po_rdy <= 1'b0;
            end
         endcase
      end
   end

   assign po_first__RDY = r_po_rdy;
   assign po_deq__RDY   = r_po_rdy;
   assign po_first      = r_po_data;
   assign po_first_last = r_po_last;
   assign oversize      = r_oversize;
   assign pkt_count     = r_pkt_count;

endmodule
`default_nettype wire

// File: tb/tb_noc_pkt_framer.sv
`default_nettype none
// ============================================================================
// Module   : tb_noc_pkt_framer
// Purpose  : Self-checking bench for noc_pkt_framer. Packets are described
//            as flit lists; the expected framed stream (header + payload,
//            truncated to DEPTH) is built from those lists and compared with
//            the flits the consumer actually took.
// Revision : 1.0 - initial release
// ============================================================================
module tb_noc_pkt_framer;

   localparam int W  = 128;
   localparam int D  = 16;
   localparam int LD = 4;
   localparam int LW = 16;

   logic          CLK = 1'b0;
   logic          RST = 1'b1;
   logic          pi_enq__ENA = 1'b0;
   logic          pi_enq__RDY;
   logic [W-1:0]  pi_enq_v = '0;
   logic          pi_enq_last = 1'b0;
   logic          po_first__RDY;
   logic [W-1:0]  po_first;
   logic          po_first_last;
   logic          po_deq__ENA = 1'b0;
   logic          po_deq__RDY;
   logic          oversize;
   logic [LW-1:0] pkt_count;

   noc_pkt_framer #(
      .WIDTH(W), .DEPTH(D), .LDEPTH(LD), .LEN_WIDTH(LW), .TRUNCATE(1)
   ) dut (
      .CLK(CLK), .RST(RST),
      .pi_enq__ENA(pi_enq__ENA), .pi_enq__RDY(pi_enq__RDY),
      .pi_enq_v(pi_enq_v), .pi_enq_last(pi_enq_last),
      .po_first__RDY(po_first__RDY), .po_first(po_first),
      .po_first_last(po_first_last),
      .po_deq__ENA(po_deq__ENA), .po_deq__RDY(po_deq__RDY),
      .oversize(oversize), .pkt_count(pkt_count)
   );

   always #5 CLK = ~CLK;

   int n_cmp = 0;
   int n_err = 0;

   logic [W-1:0] in_d [$];
   logic         in_l [$];
   logic [W:0]   exp_q [$];
   logic [W:0]   obs_q [$];
   bit           pump_to;
   int           pump_cycles;

   initial begin
      #900000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   // Reference: a packet of n flits is framed as a header holding
   // min(n, D) followed by the first min(n, D) flits, last on the final one.
   task automatic add_pkt(input int n);
      int len;
      logic [W-1:0] d;
      len = (n > D) ? D : n;
      exp_q.push_back({1'b0, W'(len)});
      for (int i = 0; i < n; i++) begin
         d = {$urandom(), $urandom(), $urandom(), $urandom()};
         in_d.push_back(d);
         in_l.push_back(i == n - 1);
         if (i < len)
            exp_q.push_back({(i == len - 1), d});
      end
   endtask

   task automatic clear_q();
      in_d.delete(); in_l.delete(); exp_q.delete(); obs_q.delete();
   endtask

   task automatic do_reset();
      pi_enq__ENA = 1'b0;
      po_deq__ENA = 1'b0;
      RST = 1'b1;
      repeat (2) @(negedge CLK);
      RST = 1'b0;
      @(negedge CLK);
   endtask

   // Drives queued input flits and takes output flits with the given
   // percentage probabilities; records taken flits into obs_q.
   task automatic pump(input int pin, input int pout, input int max_cyc, input bit feed_only);
      int cyc;
      cyc = 0;
      while ((in_d.size() > 0 || (!feed_only && obs_q.size() < exp_q.size())) && cyc < max_cyc) begin
         @(negedge CLK);
         cyc++;
         po_deq__ENA = po_first__RDY && ($urandom_range(99) < pout);
         if (po_deq__ENA)
            obs_q.push_back({po_first_last, po_first});
         if (in_d.size() > 0 && pi_enq__RDY && ($urandom_range(99) < pin)) begin
            pi_enq__ENA = 1'b1;
            pi_enq_v    = in_d.pop_front();
            pi_enq_last = in_l.pop_front();
         end else begin
            pi_enq__ENA = 1'b0;
         end
      end
      pump_to = (in_d.size() > 0 || (!feed_only && obs_q.size() < exp_q.size()));
      pump_cycles = cyc;
      @(negedge CLK);
      pi_enq__ENA = 1'b0;
      po_deq__ENA = 1'b0;
   endtask

   task automatic test_reset();
      RST = 1'b1;
      @(negedge CLK);
      n_cmp++;
      if ({po_first__RDY, po_deq__RDY, po_first_last, oversize, pi_enq__RDY} !== 5'b0) begin
         n_err++;
         $display("FAIL reset_flags: got %b want 00000",
                  {po_first__RDY, po_deq__RDY, po_first_last, oversize, pi_enq__RDY});
      end
      n_cmp++;
      if (po_first !== '0 || pkt_count !== '0) begin
         n_err++;
         $display("FAIL reset_values: po_first %h pkt_count %0d want 0/0", po_first, pkt_count);
      end
      RST = 1'b0;
      @(negedge CLK);
      n_cmp++;
      if (pi_enq__RDY !== 1'b1) begin
         n_err++;
         $display("FAIL reset_release_rdy: got %b want 1", pi_enq__RDY);
      end
   endtask

   task automatic test_single();
      logic [W-1:0] cd;
      logic         cl;
      do_reset(); clear_q();
      add_pkt(3);
      cd = in_d.pop_back(); cl = in_l.pop_back();
      pump(100, 0, 50, 1'b1);
      n_cmp++;
      if (po_first__RDY !== 1'b0) begin
         n_err++;
         $display("FAIL single_no_hdr_early: got %b want 0", po_first__RDY);
      end
      in_d.push_back(cd); in_l.push_back(cl);
      pump(100, 0, 50, 1'b1);
      n_cmp++;
      if ({po_first__RDY, po_first_last, po_first} !== {2'b10, W'(3)}) begin
         n_err++;
         $display("FAIL single_hdr_latency: rdy %b last %b data %h want 1/0/3",
                  po_first__RDY, po_first_last, po_first);
      end
      pump(100, 100, 50, 1'b0);
      n_cmp++;
      if (pump_to || obs_q.size() != exp_q.size()) begin
         n_err++;
         $display("FAIL single_count: got %0d flits want %0d", obs_q.size(), exp_q.size());
      end
      for (int i = 0; i < obs_q.size() && i < exp_q.size(); i++) begin
         n_cmp++;
         if (obs_q[i] !== exp_q[i]) begin
            n_err++;
            $display("FAIL single_flit%0d: got %h want %h", i, obs_q[i], exp_q[i]);
         end
      end
      n_cmp++;
      if (pkt_count !== LW'(1)) begin
         n_err++;
         $display("FAIL single_pkt_count: got %0d want 1", pkt_count);
      end
   endtask

   task automatic test_back_to_back();
      do_reset(); clear_q();
      add_pkt(1); add_pkt(2);
      pump(100, 0, 50, 1'b1);
      pump(100, 100, 50, 1'b0);
      n_cmp++;
      if (pump_to || pump_cycles != 5) begin
         n_err++;
         $display("FAIL b2b_cycles: got %0d cycles want 5", pump_cycles);
      end
      for (int i = 0; i < obs_q.size() && i < exp_q.size(); i++) begin
         n_cmp++;
         if (obs_q[i] !== exp_q[i]) begin
            n_err++;
            $display("FAIL b2b_flit%0d: got %h want %h", i, obs_q[i], exp_q[i]);
         end
      end
      n_cmp++;
      if (pkt_count !== LW'(2)) begin
         n_err++;
         $display("FAIL b2b_pkt_count: got %0d want 2", pkt_count);
      end
   endtask

   task automatic test_stall_full();
      do_reset(); clear_q();
      for (int p = 0; p < 4; p++) add_pkt(4);
      pump(100, 0, 100, 1'b1);
      n_cmp++;
      if (pump_to || pump_cycles != 16) begin
         n_err++;
         $display("FAIL full_accept: got %0d cycles want 16", pump_cycles);
      end
      n_cmp++;
      if (pi_enq__RDY !== 1'b0) begin
         n_err++;
         $display("FAIL full_rdy_low: got %b want 0", pi_enq__RDY);
      end
      add_pkt(1);
      pump(100, 100, 200, 1'b0);
      n_cmp++;
      if (pump_to || obs_q.size() != exp_q.size()) begin
         n_err++;
         $display("FAIL full_count: got %0d flits want %0d", obs_q.size(), exp_q.size());
      end
      for (int i = 0; i < obs_q.size() && i < exp_q.size(); i++) begin
         n_cmp++;
         if (obs_q[i] !== exp_q[i]) begin
            n_err++;
            $display("FAIL full_flit%0d: got %h want %h", i, obs_q[i], exp_q[i]);
         end
      end
   endtask

   task automatic test_oversize();
      do_reset(); clear_q();
      add_pkt(20); add_pkt(3);
      pump(80, 70, 500, 1'b0);
      n_cmp++;
      if (pump_to || obs_q.size() != exp_q.size()) begin
         n_err++;
         $display("FAIL ovs_count: got %0d flits want %0d", obs_q.size(), exp_q.size());
      end
      for (int i = 0; i < obs_q.size() && i < exp_q.size(); i++) begin
         n_cmp++;
         if (obs_q[i] !== exp_q[i]) begin
            n_err++;
            $display("FAIL ovs_flit%0d: got %h want %h", i, obs_q[i], exp_q[i]);
         end
      end
      n_cmp++;
      if (oversize !== 1'b1 || pkt_count !== LW'(2)) begin
         n_err++;
         $display("FAIL ovs_flags: oversize %b pkt_count %0d want 1/2", oversize, pkt_count);
      end
   endtask

   task automatic test_reset_mid();
      do_reset(); clear_q();
      add_pkt(5);
      pump(100, 0, 50, 1'b1);
      pump(100, 100, 3, 1'b0);
      n_cmp++;
      if (obs_q.size() != 3 || obs_q[0] !== exp_q[0] || obs_q[2] !== exp_q[2]) begin
         n_err++;
         $display("FAIL rstmid_pre: got %0d flits want 3 matching", obs_q.size());
      end
      RST = 1'b1;
      #1;
      n_cmp++;
      if ({po_first__RDY, po_first_last, pi_enq__RDY} !== 3'b0 || po_first !== '0 || pkt_count !== '0) begin
         n_err++;
         $display("FAIL rstmid_async: rdy %b last %b inrdy %b data %h cnt %0d want all 0",
                  po_first__RDY, po_first_last, pi_enq__RDY, po_first, pkt_count);
      end
      @(negedge CLK);
      RST = 1'b0;
      clear_q();
      add_pkt(2);
      pump(100, 100, 50, 1'b0);
      n_cmp++;
      if (pump_to || obs_q.size() != 3) begin
         n_err++;
         $display("FAIL rstmid_count: got %0d flits want 3", obs_q.size());
      end
      for (int i = 0; i < obs_q.size() && i < exp_q.size(); i++) begin
         n_cmp++;
         if (obs_q[i] !== exp_q[i]) begin
            n_err++;
            $display("FAIL rstmid_flit%0d: got %h want %h", i, obs_q[i], exp_q[i]);
         end
      end
      n_cmp++;
      if (pkt_count !== LW'(1)) begin
         n_err++;
         $display("FAIL rstmid_pkt_count: got %0d want 1", pkt_count);
      end
   endtask

   task automatic test_random();
      do_reset(); clear_q();
      for (int p = 0; p < 1000; p++) add_pkt($urandom_range(D, 1));
      pump(70, 60, 60000, 1'b0);
      n_cmp++;
      if (pump_to || obs_q.size() != exp_q.size()) begin
         n_err++;
         $display("FAIL rand_deadlock: got %0d flits want %0d", obs_q.size(), exp_q.size());
      end
      for (int i = 0; i < obs_q.size() && i < exp_q.size(); i++) begin
         n_cmp++;
         if (obs_q[i] !== exp_q[i]) begin
            n_err++;
            $display("FAIL rand_flit%0d: got %h want %h", i, obs_q[i], exp_q[i]);
         end
      end
      n_cmp++;
      if (pkt_count !== LW'(1000) || oversize !== 1'b0) begin
         n_err++;
         $display("FAIL rand_final: pkt_count %0d oversize %b want 1000/0", pkt_count, oversize);
      end
   endtask

   initial begin
      test_reset();
      test_single();
      test_back_to_back();
      test_stall_full();
      test_oversize();
      test_reset_mid();
      test_random();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
`default_nettype wire
